// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the data-memory responder
package mem_pkg;

    localparam int DATA_W             = 16;
    localparam int ADDR_W             = 16;
    localparam int DEFAULT_LATENCY    = 2;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DUMP,
        HALTED
    } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array with registered read, shared by access and dump paths
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_resp_ctrl.sv
// rtl/mem_resp_ctrl.sv - fixed-latency data-memory responder with dump/halt; MEM_ALIGN_CHECK_EN adds alignment errors
module mem_resp_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic                  createdump,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic                  dump_valid,
    output logic [DEPTH_LOG2-1:0] dump_addr,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  halted
);

    state_t                  state;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   idx_l;
    logic [DATA_W-1:0]       data_l;
    logic                    wr_l;
    logic                    mis_l;
    logic [DEPTH_LOG2-1:0]   dump_cnt;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DEPTH_LOG2-1:0]   arr_addr;
    logic                    arr_we;
    logic [DATA_W-1:0]       arr_rdata;
    logic                    unused_addr;

    assign req_idx     = addr[DEPTH_LOG2:1];
    assign unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};
    assign dump_data   = arr_rdata;

    // The array is read every cycle; the read issued on the edge before
    // completion is what data_out captures, so IDLE must present the live index.
    always_comb begin
        arr_addr = idx_l;
        if (state == DUMP) begin
            arr_addr = dump_cnt;
        end else if (state == IDLE) begin
            arr_addr = req_idx;
        end
        arr_we = (state == BUSY) && (cnt == 4'd0) && wr_l && !mis_l;
    end

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (data_l),
        .rdata (arr_rdata)
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign err   = 1'b0;
    assign mis_l = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_l      <= '0;
            data_l     <= '0;
            wr_l       <= 1'b0;
            dump_cnt   <= '0;
            data_out   <= '0;
            stall      <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            halted     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_l      <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            dump_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable && createdump) begin
                        dump_cnt <= '0;
                        stall    <= 1'b1;
                        state    <= DUMP;
                    end else if (enable) begin
                        idx_l  <= req_idx;
                        data_l <= data_in;
                        wr_l   <= wr;
`ifdef MEM_ALIGN_CHECK_EN
                        mis_l  <= addr[0];
`endif
                        cnt    <= 4'(LATENCY - 1);
                        stall  <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!wr_l && !mis_l) begin
                            data_out <= arr_rdata;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        err   <= mis_l;
`endif
                        done  <= 1'b1;
                        stall <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DUMP: begin
                    dump_valid <= 1'b1;
                    dump_addr  <= dump_cnt;
                    dump_cnt   <= dump_cnt + 1'b1;
                    if (dump_cnt == '1) begin
                        state <= HALTED;
                    end
                end
                default: begin
                    stall  <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// tb/tb_mem_resp_ctrl.sv - randomized self-checking bench for mem_resp_ctrl against a word-array model
module tb_mem_resp_ctrl;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int LAT   = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          wr;
    logic          createdump;
    logic [15:0]   addr;
    logic [15:0]   data_in;
    logic [15:0]   data_out;
    logic          stall;
    logic          done;
    logic          err;
    logic          dump_valid;
    logic [DL-1:0] dump_addr;
    logic [15:0]   dump_data;
    logic          halted;

    logic [15:0] model [0:DEPTH-1];
    logic [15:0] exp_dout;
    int          n_checks;
    int          n_fail;

    mem_resp_ctrl #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .createdump (createdump),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One request; reports cycles from accept to done (-1 if none) and stall-high cycles.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic b2b, output int lat, output int stall_n, output logic got_err);
        if (!b2b) @(negedge clk);
        enable = 1'b1; wr = w; addr = a; data_in = d; createdump = 1'b0;
        @(posedge clk);
        lat = -1; stall_n = 0; got_err = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) enable = 1'b0;
            if (stall) stall_n++;
            if (done) begin
                lat = j;
                got_err = err;
                break;
            end
        end
    endtask

    task automatic do_op(input logic w, input logic [15:0] a, input logic [15:0] d, input logic b2b);
        int   lat;
        int   sn;
        logic e;
        int   idx;
        logic mis;
        access(w, a, d, b2b, lat, sn, e);
        idx = (int'(a) >> 1) % DEPTH;
        mis = ALIGN && a[0];
        if (!mis) begin
            if (w) model[idx] = d;
            else   exp_dout   = model[idx];
        end
        check("latency", lat, LAT);
        check("stall_cycles", sn, LAT);
        check("err", e, mis);
        check("data_out", data_out, exp_dout);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_dump_valid"}, dump_valid, 0);
        check({tag, "_dump_addr"}, dump_addr, 0);
        check({tag, "_dump_data"}, dump_data, 0);
        check({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        int   lat;
        int   sn;
        logic e;
        int   beats;
        n_checks = 0; n_fail = 0; exp_dout = 16'h0;
        rst_n = 1'b0; enable = 1'b0; wr = 1'b0; createdump = 1'b0; addr = '0; data_in = '0;
        #23;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 16'(i * 2), 16'($urandom), 1'b0);

        do_op(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        do_op(1'b0, 16'h0010, 16'h0000, 1'b0);
        check("raw_beef", data_out, 16'hBEEF);
        do_op(1'b1, 16'h0802, 16'h1234, 1'b0);
        do_op(1'b0, 16'h0002, 16'h0000, 1'b1);
        check("wrap_1234", data_out, 16'h1234);
`ifdef MEM_ALIGN_CHECK_EN
        do_op(1'b0, 16'h0011, 16'h0000, 1'b0);
        check("align_hold", data_out, 16'h1234);
`endif

        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        do_op(1'b1, 16'h0020, 16'h0000, 1'b0);
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'h5555;
        @(posedge clk);
        @(negedge clk) enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        exp_dout = 16'h0;
        @(negedge clk) rst_n = 1'b1;
        do_op(1'b0, 16'h0020, 16'h0000, 1'b0);
        check("rst_write_dropped", data_out, 16'h0000);

        @(negedge clk);
        enable = 1'b0; createdump = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("cd_noen_valid", dump_valid, 0);
            check("cd_noen_stall", stall, 0);
        end
        createdump = 1'b0;
        do_op(1'b0, 16'h0020, 16'h0000, 1'b0);

        for (int i = 0; i < 4; i++) do_op(1'b1, 16'(i * 2), 16'hA000 + 16'(i), 1'b0);
        @(negedge clk);
        enable = 1'b1; createdump = 1'b1; wr = 1'b1; addr = 16'h0000; data_in = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0; createdump = 1'b0;
        check("dump_stall_start", stall, 1);
        beats = 0;
        for (int c = 0; c < 1200 && !halted; c++) begin
            @(negedge clk);
            if (dump_valid) begin
                check("dump_addr", dump_addr, beats);
                check("dump_data", dump_data, model[beats % DEPTH]);
                check("dump_stall", stall, 1);
                beats++;
            end
        end
        check("dump_beats", beats, DEPTH);
        check("halted", halted, 1);
        check("halted_stall", stall, 0);

        access(1'b0, 16'h0006, 16'h0000, 1'b0, lat, sn, e);
        check("halted_no_done", lat, -1);
        check("halted_no_stall", sn, 0);
        check("halted_still", halted, 1);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_dout = 16'h0;
        do_op(1'b0, 16'h0006, 16'h0000, 1'b0);
        check("after_halt_a003", data_out, 16'hA003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
